// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and the queued load-return entry type for the write-back stage
package wb_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 2 ** REG_AW;
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry synchronous FIFO of wb_entry_t.
// Ports: clk, rst_n (async active-low, clears pointers and count),
//        push_i/din_i (write), pop_i/dout_o (head read, pop ignored when empty),
//        count_o (occupancy, one bit wider than the pointers).
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  wb_entry_t                  din_i,
    input  logic                       pop_i,
    output wb_entry_t                  dout_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    wb_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [CW-1:0]     cnt_q;
    logic              do_pop;
    assign do_pop  = pop_i & (cnt_q != '0);
    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: merges ALU results and FIFO-buffered load returns onto the register-file
// write port and tracks outstanding loads in a per-register scoreboard.
// Ports: clk, rst_n (async active-low); alu_valid/alu_rd/alu_data (always accepted);
//        ld_valid/ld_ready/ld_rd/ld_data (load-return handshake); issue_ld/issue_rd (sets busy);
//        busy (scoreboard); we/WriteAddr/WriteData (registered write port); fifo_count.
// Optional macro WB_BYPASS_EN: a load arriving with the FIFO empty and the ALU idle
// is written straight to the output registers instead of being queued.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_valid,
    input  logic [REG_AW-1:0]      alu_rd,
    input  logic [XLEN-1:0]        alu_data,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [REG_AW-1:0]      ld_rd,
    input  logic [XLEN-1:0]        ld_data,
    input  logic                   issue_ld,
    input  logic [REG_AW-1:0]      issue_rd,
    output logic [NREG-1:0]        busy,
    output logic                   we,
    output logic [REG_AW-1:0]      WriteAddr,
    output logic [XLEN-1:0]        WriteData,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    wb_entry_t         head, sel;
    logic              ld_fire, fifo_empty, pop, byp, push, sel_v, ret_v, we_d;
    logic [REG_AW-1:0] ret_rd;
    logic [NREG-1:0]   set_m, clr_m, busy_d, busy_q;
    logic              we_q;
    logic [REG_AW-1:0] waddr_q;
    logic [XLEN-1:0]   wdata_q;
    // Readiness comes only from the registered count, so a full FIFO refuses even while popping.
    assign ld_ready   = fifo_count < FULL;
    assign ld_fire    = ld_valid & ld_ready;
    assign fifo_empty = fifo_count == '0;
    assign pop        = ~alu_valid & ~fifo_empty;
`ifdef WB_BYPASS_EN
    assign byp = ld_fire & fifo_empty & ~alu_valid;
`else
    assign byp = 1'b0;
`endif
    assign push = ld_fire & ~byp;
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (wb_entry_t'{ld_rd, ld_data}),
        .pop_i   (pop),
        .dout_o  (head),
        .count_o (fifo_count)
    );
    always_comb begin
        sel    = alu_valid ? wb_entry_t'{alu_rd, alu_data} : pop ? head : wb_entry_t'{ld_rd, ld_data};
        sel_v  = alu_valid | pop | byp;
        we_d   = sel_v & (sel.rd != '0);
        ret_v  = pop | byp;
        ret_rd = pop ? head.rd : ld_rd;
        clr_m  = ret_v ? NREG'(1) << ret_rd : '0;
        set_m  = (issue_ld && issue_rd != '0) ? NREG'(1) << issue_rd : '0;
        // Set is applied after clear so a same-cycle reissue keeps the bit; x0 is never tracked.
        busy_d = ((busy_q & ~clr_m) | set_m) & ~NREG'(1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
        end else begin
            we_q   <= we_d;
            busy_q <= busy_d;
            if (we_d) begin
                waddr_q <= sel.rd;
                wdata_q <= sel.data;
            end
        end
    end
    assign we        = we_q;
    assign WriteAddr = waddr_q;
    assign WriteData = wdata_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed self-checking bench for reg_writeback (default build)
module tb_reg_writeback;
    import wb_pkg::*;
    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              alu_valid = 1'b0;
    logic [REG_AW-1:0] alu_rd = '0;
    logic [XLEN-1:0]   alu_data = '0;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [REG_AW-1:0] ld_rd = '0;
    logic [XLEN-1:0]   ld_data = '0;
    logic              issue_ld = 1'b0;
    logic [REG_AW-1:0] issue_rd = '0;
    logic [NREG-1:0]   busy;
    logic              we;
    logic [REG_AW-1:0] WriteAddr;
    logic [XLEN-1:0]   WriteData;
    logic [2:0]        fifo_count;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    reg_writeback #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .issue_ld(issue_ld), .issue_rd(issue_rd), .busy(busy),
        .we(we), .WriteAddr(WriteAddr), .WriteData(WriteData), .fifo_count(fifo_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [31:0] c);
        chk({tag, "_we"}, 32'(we), 32'd1);
        chk({tag, "_addr"}, 32'(WriteAddr), a);
        chk({tag, "_data"}, WriteData, d);
        chk({tag, "_cnt"}, 32'(fifo_count), c);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_addr", 32'(WriteAddr), 32'd0);
        chk("rst_data", WriteData, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_cnt", 32'(fifo_count), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rdy_after_rst", 32'(ld_ready), 32'd1);

        // ALU single write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        tick();
        wr("alu", 32'd5, 32'h1234, 32'd0);
        alu_valid = 1'b0;
        tick();
        chk("alu_idle_we", 32'(we), 32'd0);
        chk("alu_hold_addr", 32'(WriteAddr), 32'd5);

        // load path with scoreboard
        issue_ld = 1'b1; issue_rd = 5'd7;
        tick();
        chk("busy7_set", busy, 32'h80);
        issue_ld = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hDEADBEEF;
        tick();
        chk("ld_queued_cnt", 32'(fifo_count), 32'd1);
        chk("ld_queued_we", 32'(we), 32'd0);
        chk("ld_queued_busy", busy, 32'h80);
        ld_valid = 1'b0;
        tick();
        wr("ld7", 32'd7, 32'hDEADBEEF, 32'd0);
        chk("busy7_clr", busy, 32'd0);

        // ALU priority over queued loads
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'hA;
        tick();
        wr("pri_pre1", 32'd9, 32'h99, 32'd1);
        ld_rd = 5'd4; ld_data = 32'hB;
        tick();
        wr("pri_pre2", 32'd9, 32'h99, 32'd2);
        ld_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            alu_data = 32'h900 + 32'(i);
            tick();
            wr("pri_alu", 32'd9, 32'h900 + 32'(i), 32'd2);
        end
        alu_valid = 1'b0;
        tick();
        wr("pri_x3", 32'd3, 32'hA, 32'd1);
        tick();
        wr("pri_x4", 32'd4, 32'hB, 32'd0);
        tick();
        chk("pri_idle_we", 32'(we), 32'd0);

        // full FIFO back-pressure
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h1;
        ld_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ld_rd = 5'(10 + i); ld_data = 32'h10 + 32'(i);
            tick();
            chk("full_fill_cnt", 32'(fifo_count), 32'(i + 1));
        end
        chk("full_not_ready", 32'(ld_ready), 32'd0);
        ld_rd = 5'd14; ld_data = 32'h14;
        tick();
        chk("full_blocked_cnt", 32'(fifo_count), 32'd4);
        alu_valid = 1'b0;
        tick();
        wr("full_pop10", 32'd10, 32'h10, 32'd3);
        tick();
        wr("full_pushpop11", 32'd11, 32'h11, 32'd3);
        ld_valid = 1'b0;
        tick();
        wr("full_pop12", 32'd12, 32'h12, 32'd2);
        tick();
        wr("full_pop13", 32'd13, 32'h13, 32'd1);
        tick();
        wr("full_pop14", 32'd14, 32'h14, 32'd0);

        // x0 destination is consumed without a write
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h55;
        tick();
        chk("x0_queued", 32'(fifo_count), 32'd1);
        ld_valid = 1'b0;
        tick();
        chk("x0_ld_we", 32'(we), 32'd0);
        chk("x0_ld_cnt", 32'(fifo_count), 32'd0);
        chk("x0_ld_addr", 32'(WriteAddr), 32'd14);
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h77;
        tick();
        chk("x0_alu_we", 32'(we), 32'd0);
        alu_valid = 1'b0;
        issue_ld = 1'b1; issue_rd = 5'd0;
        tick();
        chk("x0_busy", busy, 32'd0);

        // set wins over clear on the same register
        issue_rd = 5'd6;
        tick();
        chk("busy6_set", busy, 32'h40);
        issue_ld = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd6; ld_data = 32'h66;
        tick();
        ld_valid = 1'b0;
        issue_ld = 1'b1; issue_rd = 5'd6;
        tick();
        wr("coll_x6", 32'd6, 32'h66, 32'd0);
        chk("busy6_kept", busy, 32'h40);
        issue_ld = 1'b0;

        // reset mid-operation flushes the queue and scoreboard
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h2;
        ld_valid = 1'b1; issue_ld = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            ld_rd = 5'(i); ld_data = 32'(i); issue_rd = 5'(i);
            tick();
        end
        chk("pre_rst_cnt", 32'(fifo_count), 32'd3);
        chk("pre_rst_busy", busy, 32'h4E);
        alu_valid = 1'b0; ld_valid = 1'b0; issue_ld = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(we), 32'd0);
        chk("mid_rst_busy", busy, 32'd0);
        chk("mid_rst_cnt", 32'(fifo_count), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_rdy", 32'(ld_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_no_we", 32'(we), 32'd0);
            chk("post_rst_cnt", 32'(fifo_count), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
Write-back stage feeding the register file's write port (we / WriteAddr / WriteData).
- Merges two result producers:
  - the single-cycle ALU path;
  - the variable-latency load-return path, buffered in a small FIFO.
- Keeps a per-register pending-load scoreboard that decode uses to stall on read-after-load hazards.
- Sits between the execute/memory stages and the register file.

Parameters:
XLEN, 32, data width
REG_AW, 5, register address width
DEPTH, 4, load-return FIFO entries (power of 2, ≥2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU result present this cycle, always accepted
alu_rd  in  REG_AW  ALU destination register
alu_data  in  XLEN  ALU result
ld_valid  in  1  load return valid
ld_ready  out  1  load return accepted
ld_rd  in  REG_AW  load destination register
ld_data  in  XLEN  load data
issue_ld  in  1  decode issued a load this cycle
issue_rd  in  REG_AW  destination of the issued load
busy  out  2**REG_AW  scoreboard; bit r = load to xr outstanding
we  out  1  register-file write enable (registered)
WriteAddr  out  REG_AW  register-file write address (registered)
WriteData  out  XLEN  register-file write data (registered)
fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: async on rst_n low.
  - we=0, WriteAddr=0, WriteData=0.
  - busy=0, fifo_count=0, FIFO pointers=0.
  - ld_ready=1 once rst_n is high.
- Reset asserted mid-operation flushes all queued loads and clears the scoreboard. No write is issued for flushed entries.
- Load handshake: transfer when ld_valid & ld_ready.
  - ld_ready = (fifo_count < DEPTH), combinational from registered count.
  - No push-through-when-full: at full, ld_ready=0 even if a pop occurs that cycle.
- Per-cycle selection:
  - alu_valid=1 → ALU wins: we<=1, WriteAddr<=alu_rd, WriteData<=alu_data.
  - Else FIFO non-empty → pop head: we<=1, WriteAddr<=head.rd, WriteData<=head.data.
  - Else → we<=0; WriteAddr/WriteData hold.
- Latency:
  - ALU: alu_valid at cycle N → we at N+1.
  - Load: handshake at N → in FIFO at N+1 → popped at N+1 if no ALU → we at N+2.
- Destination x0: a selected entry with rd==0 is consumed (ALU or pop) but drives we<=0. x0 never written.
- Push and pop in the same cycle: fifo_count unchanged; ordering stays FIFO.
- Starvation: continuous alu_valid stalls the FIFO indefinitely. Allowed; the pipeline guarantees bubbles.
- Scoreboard:
  - Set busy[issue_rd] when issue_ld & issue_rd≠0.
  - Clear busy[rd] on the edge where a load entry with that rd is popped (same edge we rises).
  - Set and clear of the same bit in one cycle: set wins.
  - busy[0] is constant 0.
  - An ALU write to a busy register does not touch the scoreboard.
- Widths: fifo_count is one bit wider than the pointers; pointers wrap modulo DEPTH.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: when the FIFO is empty and alu_valid=0, a load handshake at cycle N is written directly to the output registers → we at N+1. It is not pushed, and busy clears on that same edge.
- Undefined: every load passes through the FIFO; minimum load latency is 2 cycles.

Decomposition:
- Package wb_pkg: XLEN, REG_AW, NREG=2**REG_AW constants; typedef wb_entry_t {rd[REG_AW], data[XLEN]}.
- One sub-module, wb_fifo: DEPTH-entry synchronous FIFO of wb_entry_t with push/pop/count. Async active-low reset on pointers and count.
- Top level holds the arbiter, output registers and scoreboard.

Test Plan:
- ALU write: alu_valid=1, alu_rd=5, alu_data=0x1234 → next cycle we=1, WriteAddr=5, WriteData=0x1234; fifo_count stays 0.
- Load path and scoreboard:
  - issue_ld with issue_rd=7 → busy[7]=1.
  - Then ld_rd=7, ld_data=0xDEADBEEF with ALU idle → we=1 to x7 two cycles after the handshake (one cycle with WB_BYPASS_EN); busy[7]=0 on the same edge.
- ALU priority:
  - Preload 2 loads (x3=0xA, x4=0xB), then hold alu_valid 3 cycles writing x9.
  - → 3 writes to x9, then x3, then x4, in order; fifo_count goes 2→2→2→1→0.
- Full FIFO: hold alu_valid and push DEPTH=4 loads → ld_ready=0 at count 4; a 5th ld_valid is not accepted until the first pop.
- x0 and set/clear collision:
  - Load with rd=0 → consumed with we=0.
  - Pop for x6 in the same cycle as issue_ld to x6 → busy[6] stays 1.
- Reset mid-operation: 3 queued loads with busy bits set, pulse rst_n low for 1 cycle.
  - → we=0, busy=0, fifo_count=0 immediately.
  - → no writes afterward; ld_ready=1 once rst_n is high.
